ram_rd_stream: RTL

//  Read-side controller for the single-clock simple dual-port RAM (dout = ram[raddr_reg]).
//  On a start command it walks rd_len consecutive addresses from start_addr.
//  It issues read addresses, absorbs the RAM's one-cycle read latency, and emits a

---
 rtl/ram_rd_stream.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ram_rd_stream.sv
// Read-side stream controller for a single-clock simple dual-port RAM.
// Walks rd_len consecutive addresses, absorbs the read latency and emits a valid/ready stream.
module ram_rd_stream #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH:0]   rd_len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] raddr,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AWIDTH:0]   LEN_ZERO  = {(AWIDTH+1){1'b0}};
    localparam logic [AWIDTH:0]   LEN_ONE   = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] ADDR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] ADDR_ZERO = {AWIDTH{1'b0}};
    localparam logic [DWIDTH-1:0] DATA_ZERO = {DWIDTH{1'b0}};
    // The address register and the RAM read register form a two-stage round trip,
    // so the output buffer needs three slots to sustain one word per clock.
    localparam logic [2:0]        BUF_SLOTS = 3'd3;

    state_t state_r;
    state_t state_s;

    logic [AWIDTH:0]   len_r;
    logic [AWIDTH:0]   issue_cnt_r;
    logic [AWIDTH-1:0] next_addr_r;
    logic [AWIDTH-1:0] raddr_r;
    logic              iss_r;
    logic              iss_last_r;
    logic              infl_r;
    logic              infl_last_r;
    logic              busy_r;
    logic              done_r;
    logic              m_valid_r;

    logic [DWIDTH-1:0] buf_data_r [0:2];
    logic              buf_last_r [0:2];
    logic [1:0]        occ_r;

    logic [DWIDTH-1:0] buf_data_s [0:2];
    logic              buf_last_s [0:2];
    logic [1:0]        occ_s;
    logic [1:0]        occ_pop_s;
    logic [2:0]        outstanding_s;
    logic              pop_s;
    logic              room_s;

    logic              accept_s;
    logic              zero_cmd_s;
    logic              issue_s;
    logic              issue_last_s;
    logic [AWIDTH-1:0] issue_addr_s;
    logic              drain_fin_s;

    // Output buffer: pop from the head, append the word returning from the RAM.
    always_comb begin
        pop_s         = m_valid_r && m_ready;
        outstanding_s = {2'b00, iss_r} + {2'b00, infl_r} + {1'b0, occ_r} - {2'b00, pop_s};
        room_s        = (outstanding_s < BUF_SLOTS);
        buf_data_s    = buf_data_r;
        buf_last_s    = buf_last_r;
        occ_pop_s     = pop_s ? (occ_r - 2'd1) : occ_r;
        if (pop_s) begin
            buf_data_s[0] = buf_data_r[1];
            buf_data_s[1] = buf_data_r[2];
            buf_data_s[2] = DATA_ZERO;
            buf_last_s[0] = buf_last_r[1];
            buf_last_s[1] = buf_last_r[2];
            buf_last_s[2] = 1'b0;
        end else begin
            buf_data_s[2] = buf_data_r[2];
        end
        case ({infl_r, occ_pop_s})
            3'b100: begin
                buf_data_s[0] = ram_dout;
                buf_last_s[0] = infl_last_r;
            end
            3'b101: begin
                buf_data_s[1] = ram_dout;
                buf_last_s[1] = infl_last_r;
            end
            3'b110: begin
                buf_data_s[2] = ram_dout;
                buf_last_s[2] = infl_last_r;
            end
            default: begin
            end
        endcase
        occ_s       = occ_pop_s + {1'b0, infl_r};
        drain_fin_s = (state_r == DRAIN) && !iss_r && !infl_r && (occ_s == 2'd0);
    end

    // Command acceptance and read issue decisions for the current state.
    always_comb begin
        accept_s     = 1'b0;
        zero_cmd_s   = 1'b0;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        issue_addr_s = next_addr_r;
        case (state_r)
            IDLE: begin
                if (start && (rd_len != LEN_ZERO)) begin
                    accept_s     = 1'b1;
                    issue_s      = 1'b1;
                    issue_addr_s = start_addr;
                    issue_last_s = (rd_len == LEN_ONE);
                end else begin
                    zero_cmd_s = start;
                end
            end
            READ: begin
                if ((issue_cnt_r != len_r) && room_s) begin
                    issue_s      = 1'b1;
                    issue_last_s = ((issue_cnt_r + LEN_ONE) == len_r);
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = issue_last_s ? DRAIN : READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (issue_s && issue_last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (drain_fin_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command counters, read-address pipeline, buffer and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r       <= LEN_ZERO;
            issue_cnt_r <= LEN_ZERO;
            next_addr_r <= ADDR_ZERO;
            raddr_r     <= ADDR_ZERO;
            iss_r       <= 1'b0;
            iss_last_r  <= 1'b0;
            infl_r      <= 1'b0;
            infl_last_r <= 1'b0;
            occ_r       <= 2'd0;
            m_valid_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                buf_data_r[i] <= DATA_ZERO;
                buf_last_r[i] <= 1'b0;
            end
        end else begin
            if (accept_s) begin
                len_r       <= rd_len;
                issue_cnt_r <= LEN_ONE;
            end else if (issue_s) begin
                issue_cnt_r <= issue_cnt_r + LEN_ONE;
            end
            if (issue_s) begin
                raddr_r     <= issue_addr_s;
                next_addr_r <= issue_addr_s + ADDR_ONE;
            end
            iss_r       <= issue_s;
            iss_last_r  <= issue_s && issue_last_s;
            infl_r      <= iss_r;
            infl_last_r <= iss_last_r;
            buf_data_r  <= buf_data_s;
            buf_last_r  <= buf_last_s;
            occ_r       <= occ_s;
            m_valid_r   <= (occ_s != 2'd0);
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (drain_fin_s) begin
                busy_r <= 1'b0;
            end
            done_r <= zero_cmd_s || drain_fin_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign raddr   = raddr_r;
    assign m_data  = buf_data_r[0];
    assign m_last  = buf_last_r[0];
    assign m_valid = m_valid_r;

endmodule
